// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: RAW-hazard scoreboard, branch/JAL fetch-hold sequencer and
// stall/flush performance counters for the 5-stage FE/ID/EX/MEM/WB pipeline.
module pipeline_ctrl #(
    parameter int REGNOBITS = 4,
    parameter int CNTBITS   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 id_valid,
    input  logic [REGNOBITS-1:0] id_rs,
    input  logic [REGNOBITS-1:0] id_rt,
    input  logic                 id_use_rs,
    input  logic                 id_use_rt,
    input  logic                 id_wr_reg,
    input  logic [REGNOBITS-1:0] id_wregno,
    input  logic                 id_is_ctl,
    input  logic                 ex_resolve,
    input  logic                 ex_mispred,
    input  logic                 wb_wr_reg,
    input  logic [REGNOBITS-1:0] wb_wregno,
    output logic                 stall_fe,
    output logic                 bubble_id,
    output logic                 flush_fe,
    output logic                 pc_load,
    output logic                 issue,
    output logic                 sb_err,
    output logic [CNTBITS-1:0]   stall_cnt,
    output logic [CNTBITS-1:0]   flush_cnt
);
    localparam int NREG = 1 << REGNOBITS;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [NREG-1:0][1:0]    r_pend;
    logic [NREG-1:0][1:0]    w_pend_nxt;
    logic                    w_err_set;
    logic                    r_sb_err;
    logic [CNTBITS-1:0]      r_stall_cnt;
    logic [CNTBITS-1:0]      r_flush_cnt;

    logic w_wb_hit_rs;
    logic w_wb_hit_rt;
    logic w_haz_rs;
    logic w_haz_rt;
    logic w_data_haz;
    logic w_issue;
    logic w_bubble;
    logic w_stall_fe;
    logic w_flush_fe;
    logic w_pc_load;

    // Hazard detect: eff = pend - wb_retire is nonzero exactly when pend differs
    // from the 0/1 retire count, which also flags the pend=0 underflow case.
    always_comb begin
        w_wb_hit_rs = wb_wr_reg && (wb_wregno == id_rs);
        w_wb_hit_rt = wb_wr_reg && (wb_wregno == id_rt);
        w_haz_rs    = id_use_rs && (r_pend[id_rs] != {1'b0, w_wb_hit_rs});
        w_haz_rt    = id_use_rt && (r_pend[id_rt] != {1'b0, w_wb_hit_rt});
        w_data_haz  = id_valid && (w_haz_rs || w_haz_rt);
    end

    // Control FSM next-state and outputs; reset forces the quiescent output set.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_bubble    = 1'b1;
        w_stall_fe  = 1'b0;
        w_flush_fe  = 1'b0;
        w_pc_load   = 1'b0;
        if (reset_n) begin
            case (r_state)
                ST_RUN: begin
                    w_issue    = id_valid && !w_data_haz;
                    w_bubble   = !w_issue;
                    w_stall_fe = w_data_haz;
                    if (w_issue && id_is_ctl) begin
                        w_stall_fe  = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    w_stall_fe = 1'b1;
                    if (ex_resolve) begin
                        w_stall_fe  = 1'b0;
                        w_pc_load   = ex_mispred;
                        w_flush_fe  = ex_mispred;
                        w_state_nxt = ST_RUN;
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    // Scoreboard next values: one writer enters at issue, one leaves at WB.
    always_comb begin
        w_pend_nxt = r_pend;
        w_err_set  = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            logic v_inc;
            logic v_dec;
            v_inc = w_issue && id_wr_reg && (id_wregno == REGNOBITS'(r));
            v_dec = wb_wr_reg && (wb_wregno == REGNOBITS'(r));
            if (v_inc && !v_dec) begin
                if (r_pend[r] == 2'd3) w_err_set = 1'b1;
                else                   w_pend_nxt[r] = r_pend[r] + 2'd1;
            end else if (v_dec && !v_inc) begin
                if (r_pend[r] == 2'd0) w_err_set = 1'b1;
                else                   w_pend_nxt[r] = r_pend[r] - 2'd1;
            end
        end
    end

    // State register, scoreboard and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_RUN;
            r_pend   <= '0;
            r_sb_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pend   <= w_pend_nxt;
            r_sb_err <= r_sb_err || w_err_set;
        end
    end

    // Performance counters; both wrap naturally at 2^CNTBITS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_bubble && id_valid) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_pc_load)            r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign issue     = w_issue;
    assign bubble_id = w_bubble;
    assign stall_fe  = w_stall_fe;
    assign flush_fe  = w_flush_fe;
    assign pc_load   = w_pc_load;
    assign sb_err    = r_sb_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_pipeline_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid, id_use_rs, id_use_rt, id_wr_reg, id_is_ctl;
    logic [3:0]  id_rs, id_rt, id_wregno, wb_wregno;
    logic        ex_resolve, ex_mispred, wb_wr_reg;
    logic        stall_fe, bubble_id, flush_fe, pc_load, issue, sb_err;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl #(.REGNOBITS(4), .CNTBITS(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wr_reg(id_wr_reg), .id_wregno(id_wregno), .id_is_ctl(id_is_ctl),
        .ex_resolve(ex_resolve), .ex_mispred(ex_mispred),
        .wb_wr_reg(wb_wr_reg), .wb_wregno(wb_wregno),
        .stall_fe(stall_fe), .bubble_id(bubble_id), .flush_fe(flush_fe),
        .pc_load(pc_load), .issue(issue), .sb_err(sb_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: per-register in-flight writer counts and a wait flag.
    int        m_pend [16];
    bit        m_wait, m_err;
    bit [31:0] m_stall, m_flush;
    bit        e_issue, e_bub, e_stall, e_flush, e_pcl;

    // Random-traffic environment: writers travel EX -> MEM -> WB.
    bit        ex_v, mem_v, wbs_v;
    bit [3:0]  ex_n, mem_n, wbs_n;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        foreach (m_pend[r]) m_pend[r] = 0;
        m_wait  = 1'b0;
        m_err   = 1'b0;
        m_stall = '0;
        m_flush = '0;
    endfunction

    function automatic void model_comb();
        int  eff_s, eff_t;
        bit  haz;
        e_issue = 1'b0; e_bub = 1'b1; e_stall = 1'b0; e_flush = 1'b0; e_pcl = 1'b0;
        if (!reset_n) return;
        eff_s = m_pend[id_rs] - ((wb_wr_reg && wb_wregno == id_rs) ? 1 : 0);
        eff_t = m_pend[id_rt] - ((wb_wr_reg && wb_wregno == id_rt) ? 1 : 0);
        haz   = id_valid && ((id_use_rs && eff_s != 0) || (id_use_rt && eff_t != 0));
        if (!m_wait) begin
            e_issue = id_valid && !haz;
            e_bub   = !e_issue;
            e_stall = haz || (e_issue && id_is_ctl);
        end else begin
            e_stall = !ex_resolve;
            e_pcl   = ex_resolve && ex_mispred;
            e_flush = ex_resolve && ex_mispred;
        end
    endfunction

    function automatic void model_update();
        bit inc, dec;
        for (int r = 0; r < 16; r++) begin
            inc = e_issue && id_wr_reg && (id_wregno == r[3:0]);
            dec = wb_wr_reg && (wb_wregno == r[3:0]);
            if (inc && !dec) begin
                if (m_pend[r] == 3) m_err = 1'b1; else m_pend[r]++;
            end else if (dec && !inc) begin
                if (m_pend[r] == 0) m_err = 1'b1; else m_pend[r]--;
            end
        end
        if (e_bub && id_valid) m_stall++;
        if (e_pcl) m_flush++;
        if (!m_wait) m_wait = e_issue && id_is_ctl;
        else         m_wait = !ex_resolve;
    endfunction

    // Called just after a negedge with inputs set; compares, then advances one cycle.
    task automatic run_cycle();
        if (!reset_n) model_reset();
        #1;
        model_comb();
        chk1("issue", issue, e_issue);
        chk1("bubble_id", bubble_id, e_bub);
        chk1("stall_fe", stall_fe, e_stall);
        chk1("flush_fe", flush_fe, e_flush);
        chk1("pc_load", pc_load, e_pcl);
        chk1("sb_err", sb_err, m_err);
        chk32("stall_cnt", stall_cnt, m_stall);
        chk32("flush_cnt", flush_cnt, m_flush);
        @(posedge clk);
        if (reset_n) model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_wr_reg = 1'b0; id_wregno = '0; id_is_ctl = 1'b0;
        ex_resolve = 1'b0; ex_mispred = 1'b0; wb_wr_reg = 1'b0; wb_wregno = '0;
    endtask

    task automatic id_in(input bit v, input bit [3:0] rs, input bit [3:0] rt,
                         input bit urs, input bit urt, input bit wr,
                         input bit [3:0] wno, input bit ctl);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wr_reg = wr; id_wregno = wno; id_is_ctl = ctl;
    endtask

    task automatic do_reset();
        idle();
        id_in(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk1("rst_bubble", bubble_id, 1'b1);
        chk1("rst_issue", issue, 1'b0);
        chk1("rst_stall", stall_fe, 1'b0);
        chk32("rst_stall_cnt", stall_cnt, 32'd0);
        run_cycle();
        reset_n = 1'b1;
        idle();
        ex_v = 0; mem_v = 0; wbs_v = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle();
        model_reset();
        @(negedge clk);

        // Back-to-back ALU RAW: two bubbles, dependent issues in writer's WB cycle.
        do_reset();
        id_in(1, 4'd1, 4'd2, 1, 1, 1, 4'd3, 0); #1 chk1("raw_writer_issue", issue, 1'b1); run_cycle();
        id_in(1, 4'd3, 4'd3, 1, 1, 1, 4'd4, 0); #1 chk1("raw_bubble1", bubble_id, 1'b1); run_cycle();
        #1 chk1("raw_bubble2", bubble_id, 1'b1); run_cycle();
        wb_wr_reg = 1; wb_wregno = 4'd3; #1 chk1("raw_issue_at_wb", issue, 1'b1); run_cycle();
        idle(); id_in(1, 4'd3, 4'd0, 1, 0, 0, 4'd0, 0);
        #1 chk1("raw_pend3_clear", issue, 1'b1); chk32("raw_stall_cnt", stall_cnt, 32'd2); run_cycle();

        // WB retiring the register ID reads in the same cycle: no stall.
        do_reset();
        id_in(1, 4'd0, 4'd0, 0, 0, 1, 4'd5, 0); run_cycle();
        idle(); run_cycle();
        id_in(1, 4'd5, 4'd0, 1, 0, 0, 4'd0, 0); wb_wr_reg = 1; wb_wregno = 4'd5;
        #1 chk1("wb_same_cycle_issue", issue, 1'b1); run_cycle();

        // Branch not taken: one WAIT cycle, no redirect.
        do_reset();
        id_in(1, 4'd1, 4'd2, 1, 1, 0, 4'd0, 1);
        #1 chk1("beq_issue", issue, 1'b1); chk1("beq_hold_fe", stall_fe, 1'b1); run_cycle();
        idle(); ex_resolve = 1;
        #1 chk1("beq_release", stall_fe, 1'b0); chk1("beq_no_pcload", pc_load, 1'b0);
        chk1("beq_no_flush", flush_fe, 1'b0); run_cycle();
        idle(); id_in(1, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0);
        #1 chk1("beq_run_again", issue, 1'b1); chk32("beq_flush_cnt", flush_cnt, 32'd0); run_cycle();

        // JAL mispredict: redirect and flush, resolve in RUN ignored.
        do_reset();
        id_in(1, 4'd0, 4'd0, 0, 0, 1, 4'd15, 1); run_cycle();
        idle(); id_in(1, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0);
        #1 chk1("jal_hold", stall_fe, 1'b1); chk1("jal_no_wrong_issue", issue, 1'b0); run_cycle();
        ex_resolve = 1; ex_mispred = 1;
        #1 chk1("jal_pcload", pc_load, 1'b1); chk1("jal_flush", flush_fe, 1'b1);
        chk1("jal_release", stall_fe, 1'b0); chk1("jal_wrong_path", issue, 1'b0); run_cycle();
        #1 chk1("resolve_in_run_ignored", pc_load, 1'b0); chk1("jal_run_issue", issue, 1'b1);
        chk32("jal_flush_cnt", flush_cnt, 32'd1); run_cycle();
        idle(); #1 chk32("jal_flush_cnt_hold", flush_cnt, 32'd1); chk32("jal_stall_cnt", stall_cnt, 32'd2); run_cycle();

        // Simultaneous inc/dec on r7 leaves exactly one pending writer.
        do_reset();
        id_in(1, 4'd0, 4'd0, 0, 0, 1, 4'd7, 0); run_cycle();
        wb_wr_reg = 1; wb_wregno = 4'd7; run_cycle();
        idle(); id_in(1, 4'd7, 4'd0, 1, 0, 0, 4'd0, 0);
        #1 chk1("r7_still_pending", bubble_id, 1'b1); run_cycle();
        wb_wr_reg = 1; wb_wregno = 4'd7; #1 chk1("r7_last_retire", issue, 1'b1); run_cycle();
        wb_wr_reg = 0; #1 chk1("r7_clear", issue, 1'b1); chk1("r7_no_err", sb_err, 1'b0); run_cycle();

        // Four writers to r2 with no retire: saturate at 3 and flag.
        do_reset();
        id_in(1, 4'd0, 4'd0, 0, 0, 1, 4'd2, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin #1 chk1("sat_no_err_yet", sb_err, 1'b0); end
            run_cycle();
        end
        idle(); #1 chk1("sat_sb_err", sb_err, 1'b1); run_cycle();

        // Retire with nothing pending: underflow flag.
        do_reset();
        wb_wr_reg = 1; wb_wregno = 4'd9; run_cycle();
        idle(); #1 chk1("underflow_sb_err", sb_err, 1'b1); run_cycle();

        // Reset pulsed during WAIT drops the pending redirect.
        do_reset();
        id_in(1, 4'd0, 4'd0, 0, 0, 0, 4'd0, 1); wb_wr_reg = 1; wb_wregno = 4'd9; run_cycle();
        idle(); id_in(1, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0); run_cycle();
        #1 chk1("wait_err_set", sb_err, 1'b1); chk32("wait_stall_cnt", stall_cnt, 32'd1);
        ex_resolve = 1; ex_mispred = 1; reset_n = 0;
        #1 chk1("midrst_pcload", pc_load, 1'b0); chk1("midrst_flush", flush_fe, 1'b0);
        chk1("midrst_stall", stall_fe, 1'b0); chk32("midrst_stall_cnt", stall_cnt, 32'd0);
        chk1("midrst_sb_err", sb_err, 1'b0); run_cycle();
        reset_n = 1;
        #1 chk1("postrst_no_pcload", pc_load, 1'b0); chk1("postrst_issue", issue, 1'b1);
        run_cycle();
        idle(); #1 chk32("postrst_flush_cnt", flush_cnt, 32'd0); run_cycle();

        // Randomized traffic with a consistent writer pipeline plus occasional noise.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle();
            reset_n    = ($urandom_range(0, 299) != 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            id_rs      = 4'($urandom_range(0, 5));
            id_rt      = 4'($urandom_range(0, 5));
            id_use_rs  = 1'($urandom_range(0, 1));
            id_use_rt  = 1'($urandom_range(0, 1));
            id_wr_reg  = 1'($urandom_range(0, 1));
            id_wregno  = 4'($urandom_range(0, 5));
            id_is_ctl  = ($urandom_range(0, 7) == 0);
            wb_wr_reg  = wbs_v;
            wb_wregno  = wbs_n;
            if ($urandom_range(0, 199) == 0) begin
                wb_wr_reg = 1'b1;
                wb_wregno = 4'($urandom_range(0, 15));
            end
            ex_resolve = m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            ex_mispred = 1'($urandom_range(0, 1));
            run_cycle();
            wbs_v = mem_v; wbs_n = mem_n;
            mem_v = ex_v;  mem_n = ex_n;
            ex_v  = e_issue && id_wr_reg; ex_n = id_wregno;
            if (!reset_n) begin ex_v = 0; mem_v = 0; wbs_v = 0; end
        end
        reset_n = 1'b1;
        idle();
        run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
